// File: rtl/fft_frame_dma.sv
// Frame mover between AXI-Stream and the FFT's dual-sample BRAM.
// LOAD writes one frame (optionally bit-reversed); UNLOAD streams it back out with backpressure.
module fft_frame_dma #(
    parameter int DATA_W    = 8,
    parameter int LOG2_N    = 10,
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0,
    parameter int BIT_REV   = 1,
    parameter int RD_LAT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    output logic                busy,
    output logic                done,
    output logic                err_tlast,
    input  logic [4*DATA_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    output logic [4*DATA_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [4*DATA_W-1:0] bram_din,
    input  logic [4*DATA_W-1:0] bram_dout,
    output logic [1:0]          dbg_state_o
);
    localparam int WD    = 4 * DATA_W;
    localparam int KW    = LOG2_N - 1;
    localparam int CW    = LOG2_N;
    localparam int DEPTH = RD_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int OW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]     WORDS  = CW'(1 << KW);
    localparam logic [CW-1:0]     LAST_K = CW'((1 << KW) - 1);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNLOAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic              start_acc;
    logic [CW-1:0]     k_q, rd_q, out_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [WD-1:0]     wdin_q;
    logic [RD_LAT-1:0] pipe_q;
    logic [WD-1:0]     fifo_q [DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [OW-1:0]     occ_q, inflight, slots_used;
    logic              s_beat, pop, push, rd_issue;

    function automatic logic [KW-1:0] bitrev(input logic [KW-1:0] k);
        logic [KW-1:0] r;
        for (int i = 0; i < KW; i++) r[i] = k[KW-1-i];
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] load_addr(input logic [KW-1:0] k);
        logic [KW-1:0] idx;
        idx = (BIT_REV != 0) ? bitrev(k) : k;
        return BASE + ADDR_W'(idx);
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // valid/ready: a beat moves on any cycle where both are high; the sender
    // holds tdata/tlast unchanged while valid is high and ready is low.
    assign s_axis_tready = (state_q == S_LOAD);
    assign s_beat        = s_axis_tready && s_axis_tvalid;
    assign m_axis_tvalid = (occ_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_q[rp_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (out_q == LAST_K);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push          = pipe_q[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + OW'(pipe_q[i]);
    end

    // A slot freed by this cycle's pop is reusable, which keeps full rate at depth RD_LAT+1.
    assign slots_used = occ_q - OW'(pop) + inflight;
    assign rd_issue   = (state_q == S_UNLOAD) && (rd_q != WORDS) && (slots_used < OW'(DEPTH));

    assign bram_we     = we_q;
    assign bram_addr   = (state_q == S_UNLOAD) ? BASE + ADDR_W'(rd_q) : waddr_q;
    assign bram_din    = wdin_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err_tlast   = err_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    err_d     = 1'b0;
                    state_d   = mode ? S_UNLOAD : S_LOAD;
                end
            end
            S_LOAD: begin
                if (s_beat) begin
                    if (k_q == LAST_K) begin
                        state_d = S_DONE;
                        if (!s_axis_tlast) err_d = 1'b1;
                    end else if (s_axis_tlast) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_UNLOAD: begin
                if (pop && m_axis_tlast) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            rd_q    <= '0;
            out_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdin_q  <= '0;
            pipe_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
        end else begin
            we_q <= s_beat;
            if (s_beat) begin
                waddr_q <= load_addr(k_q[KW-1:0]);
                wdin_q  <= s_axis_tdata;
                k_q     <= k_q + 1'b1;
            end
            if (start_acc) begin
                k_q    <= '0;
                rd_q   <= '0;
                out_q  <= '0;
                pipe_q <= '0;
                wp_q   <= '0;
                rp_q   <= '0;
                occ_q  <= '0;
            end else begin
                if (rd_issue) rd_q <= rd_q + 1'b1;
                pipe_q <= RD_LAT'({pipe_q, rd_issue});
                if (push) wp_q <= ptr_next(wp_q);
                if (pop) begin
                    rp_q  <= ptr_next(rp_q);
                    out_q <= out_q + 1'b1;
                end
                occ_q <= occ_q + OW'(push) - OW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wp_q] <= bram_dout;
    end
endmodule
